// File: rtl/biriscv_branch_update_arb_pkg.sv
// biriscv_branch_update_arb_pkg: branch update entry layout and stall margin shared by the arbiter slice
package biriscv_branch_update_arb_pkg;
  localparam int STALL_MARGIN = 4;
  typedef struct packed {
    logic        taken;
    logic [31:0] source;
    logic [31:0] pc;
    logic        is_call;
    logic        is_ret;
    logic        is_jmp;
  } entry_t;
  function automatic entry_t mk_entry(input logic taken, input logic [31:0] source, input logic [31:0] pc,
                                      input logic is_call, input logic is_ret, input logic is_jmp);
    return '{taken, source, pc, is_call, is_ret, is_jmp};
  endfunction
endpackage

// File: rtl/biriscv_branch_update_arb_if.sv
// biriscv_branch_update_arb_if: exec-pipe reports in, predictor update port and status out
interface biriscv_branch_update_arb_if #(parameter int DEPTH = 8);
  logic                   p0_request_i, p0_taken_i, p0_is_call_i, p0_is_ret_i, p0_is_jmp_i;
  logic [31:0]            p0_source_i, p0_pc_i;
  logic                   p1_request_i, p1_taken_i, p1_is_call_i, p1_is_ret_i, p1_is_jmp_i;
  logic [31:0]            p1_source_i, p1_pc_i;
  logic                   upd_ready_i, upd_valid_o, upd_taken_o, upd_is_call_o, upd_is_ret_o, upd_is_jmp_o;
  logic [31:0]            upd_source_o, upd_pc_o;
  logic                   stall_o, overflow_o;
  logic [$clog2(DEPTH):0] level_o;
  modport master (
    output p0_request_i, p0_taken_i, p0_source_i, p0_pc_i, p0_is_call_i, p0_is_ret_i, p0_is_jmp_i,
    output p1_request_i, p1_taken_i, p1_source_i, p1_pc_i, p1_is_call_i, p1_is_ret_i, p1_is_jmp_i,
    output upd_ready_i,
    input  upd_valid_o, upd_taken_o, upd_source_o, upd_pc_o, upd_is_call_o, upd_is_ret_o, upd_is_jmp_o,
    input  stall_o, level_o, overflow_o
  );
  modport slave (
    input  p0_request_i, p0_taken_i, p0_source_i, p0_pc_i, p0_is_call_i, p0_is_ret_i, p0_is_jmp_i,
    input  p1_request_i, p1_taken_i, p1_source_i, p1_pc_i, p1_is_call_i, p1_is_ret_i, p1_is_jmp_i,
    input  upd_ready_i,
    output upd_valid_o, upd_taken_o, upd_source_o, upd_pc_o, upd_is_call_o, upd_is_ret_o, upd_is_jmp_o,
    output stall_o, level_o, overflow_o
  );
endinterface

// File: rtl/biriscv_branch_update_fifo.sv
// biriscv_branch_update_fifo: dual-write single-read entry storage with head/tail pointers and count
module biriscv_branch_update_fifo
  import biriscv_branch_update_arb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  push_i,
  input  entry_t      data0_i,
  input  entry_t      data1_i,
  input  logic        pop_i,
  output entry_t      head_o,
  output logic [AW:0] count_o
);
  entry_t          mem [DEPTH];
  logic [AW-1:0]   head, tail;
  // push_i is the number of entries written: data0 lands at tail, data1 right after it
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head    <= '0;
      tail    <= '0;
      count_o <= '0;
    end else begin
      if (push_i != 2'd0) mem[tail] <= data0_i;
      if (push_i == 2'd2) mem[tail + AW'(1)] <= data1_i;
      tail    <= tail + AW'(push_i);
      head    <= head + AW'(pop_i);
      count_o <= count_o + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  assign head_o = mem[head];
endmodule

// File: rtl/biriscv_branch_update_arb.sv
// biriscv_branch_update_arb: merges two exec-pipe branch reports, in program order, into one predictor update port
module biriscv_branch_update_arb
  import biriscv_branch_update_arb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic clk_i,
  input logic rst_i,
  biriscv_branch_update_arb_if.slave bus
);
  entry_t      p0_e, p1_e, head;
  logic [AW:0] count, free;
  logic        valid, wr0, wr1, overflow;
  assign p0_e  = mk_entry(bus.p0_taken_i, bus.p0_source_i, bus.p0_pc_i, bus.p0_is_call_i, bus.p0_is_ret_i, bus.p0_is_jmp_i);
  assign p1_e  = mk_entry(bus.p1_taken_i, bus.p1_source_i, bus.p1_pc_i, bus.p1_is_call_i, bus.p1_is_ret_i, bus.p1_is_jmp_i);
  assign valid = count != '0;
  // space comes from the registered count only; a same-cycle pop never makes room
  assign free  = (AW+1)'(DEPTH) - count;
  assign wr0   = bus.p0_request_i && free != '0;
  assign wr1   = bus.p1_request_i && free > {{AW{1'b0}}, wr0};
  biriscv_branch_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  ({wr0 & wr1, wr0 ^ wr1}),
    .data0_i (wr0 ? p0_e : p1_e),
    .data1_i (p1_e),
    .pop_i   (valid && bus.upd_ready_i),
    .head_o  (head),
    .count_o (count)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) overflow <= 1'b0;
    else if ((bus.p0_request_i && !wr0) || (bus.p1_request_i && !wr1)) overflow <= 1'b1;
  assign bus.upd_valid_o   = valid;
  assign bus.upd_taken_o   = head.taken;
  assign bus.upd_source_o  = head.source;
  assign bus.upd_pc_o      = head.pc;
  assign bus.upd_is_call_o = head.is_call;
  assign bus.upd_is_ret_o  = head.is_ret;
  assign bus.upd_is_jmp_o  = head.is_jmp;
  assign bus.stall_o       = count > (AW+1)'(DEPTH - STALL_MARGIN);
  assign bus.level_o       = count;
  assign bus.overflow_o    = overflow;
endmodule
